// File: rtl/pkg_mem_arb.sv
// Shared types and constants for the memory access arbiter.
//   arb_state_t : arbiter FSM states
//   arb_port_t  : requester identity, also used as the round-robin pointer
//   cpu_data_acc_sz_8 / cpu_data_acc_sz_16 : access size encoding, same
//     values as the CPU's data port and the memory's data_acc_sz input
//   TIMEOUT_FILL : read data returned to a requester whose access timed out
package pkg_mem_arb;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_port_t;

  localparam logic cpu_data_acc_sz_8  = 1'b0;
  localparam logic cpu_data_acc_sz_16 = 1'b1;

  localparam logic [15:0] TIMEOUT_FILL = 16'hDEAD;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker between the fetch and data ports.
// Purely combinational.
//   fetch_req, data_req : pending requests
//   last_grant          : port granted most recently
//   grant_valid         : at least one request pending
//   grant_port          : port to grant; under contention, the one not
//                         granted last time
module mem_arb_rr_pick
  import pkg_mem_arb::*;
(
  input  logic      fetch_req,
  input  logic      data_req,
  input  arb_port_t last_grant,
  output logic      grant_valid,
  output arb_port_t grant_port
);

  always_comb begin
    grant_valid = fetch_req | data_req;
    grant_port  = FETCH;
    if (fetch_req && data_req) begin
      grant_port = (last_grant == FETCH) ? DATA : FETCH;
    end else if (data_req) begin
      grant_port = DATA;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Merges the CPU instruction-fetch port and the load/store data port into a
// single request stream for the synchronous test memory. One access is in
// flight at a time; the granted requester gets a one-cycle done pulse with
// its read data. All outputs are registered.
//
// Ports:
//   clk, reset (async, active-low)
//   fetch_req/fetch_addr -> fetch_done/fetch_rdata   (16-bit reads only)
//   data_req/data_addr/data_we/data_acc_sz/data_wdata -> data_done/data_rdata
//   mem_req_rdwr/mem_addr/mem_data_acc_sz/mem_we_8/mem_we_16/
//   mem_wdata_8/mem_wdata_16 -> memory
//   mem_rdata_8/mem_rdata_16/mem_data_ready <- memory
//   arb_err : sticky timeout flag
//
// Build option: define MEM_ACCESS_ARBITER_TIMEOUT_EN to add a watchdog on
// WAIT. Without it, WAIT waits indefinitely and arb_err is tied 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; grant a pending request (round-robin)
// WAIT  | request presented to memory, mem_* held until mem_data_ready
// RESP  | done pulse to the granted port; one idle bus cycle
module mem_access_arbiter
  import pkg_mem_arb::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_done,
  output logic [15:0]           fetch_rdata,
  input  logic                  data_req,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic                  data_we,
  input  logic                  data_acc_sz,
  input  logic [15:0]           data_wdata,
  output logic                  data_done,
  output logic [15:0]           data_rdata,
  output logic                  mem_req_rdwr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_data_acc_sz,
  output logic                  mem_we_8,
  output logic                  mem_we_16,
  output logic [7:0]            mem_wdata_8,
  output logic [15:0]           mem_wdata_16,
  input  logic [7:0]            mem_rdata_8,
  input  logic [15:0]           mem_rdata_16,
  input  logic                  mem_data_ready,
  output logic                  arb_err
);

  arb_state_t  state;
  arb_port_t   last_grant;
  logic        grant_valid;
  arb_port_t   grant_port;
  logic [15:0] rd_capture;

  mem_arb_rr_pick u_pick (
    .fetch_req   (fetch_req),
    .data_req    (data_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  assign rd_capture = (mem_data_acc_sz == cpu_data_acc_sz_16) ? mem_rdata_16
                                                              : {8'h00, mem_rdata_8};

`ifdef MEM_ACCESS_ARBITER_TIMEOUT_EN
  logic [7:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CYCLES, TIMEOUT_FILL};
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      last_grant      <= FETCH;  // data wins the first contention
      fetch_done      <= 1'b0;
      fetch_rdata     <= '0;
      data_done       <= 1'b0;
      data_rdata      <= '0;
      mem_req_rdwr    <= 1'b0;
      mem_addr        <= '0;
      mem_data_acc_sz <= 1'b0;
      mem_we_8        <= 1'b0;
      mem_we_16       <= 1'b0;
      mem_wdata_8     <= '0;
      mem_wdata_16    <= '0;
`ifdef MEM_ACCESS_ARBITER_TIMEOUT_EN
      wait_cnt        <= '0;
      arb_err         <= 1'b0;
`endif
    end else begin
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant   <= grant_port;
            mem_req_rdwr <= 1'b1;
            state        <= WAIT;
`ifdef MEM_ACCESS_ARBITER_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
            if (grant_port == FETCH) begin
              mem_addr        <= fetch_addr;
              mem_data_acc_sz <= cpu_data_acc_sz_16;
              mem_we_8        <= 1'b0;
              mem_we_16       <= 1'b0;
            end else begin
              mem_addr        <= data_addr;
              mem_data_acc_sz <= data_acc_sz;
              mem_we_8        <= data_we & (data_acc_sz == cpu_data_acc_sz_8);
              mem_we_16       <= data_we & (data_acc_sz == cpu_data_acc_sz_16);
              mem_wdata_8     <= data_wdata[7:0];
              mem_wdata_16    <= data_wdata;
            end
          end
        end
        WAIT: begin
          if (mem_data_ready) begin
            mem_req_rdwr <= 1'b0;
            mem_we_8     <= 1'b0;
            mem_we_16    <= 1'b0;
            // write enables are still the granted values here; writes keep rdata
            if (!(mem_we_8 || mem_we_16)) begin
              if (last_grant == FETCH) fetch_rdata <= rd_capture;
              else                     data_rdata  <= rd_capture;
            end
            fetch_done <= (last_grant == FETCH);
            data_done  <= (last_grant == DATA);
            state      <= RESP;
`ifdef MEM_ACCESS_ARBITER_TIMEOUT_EN
          end else if (wait_cnt == TIMEOUT_CYCLES - 8'd1) begin
            mem_req_rdwr <= 1'b0;
            mem_we_8     <= 1'b0;
            mem_we_16    <= 1'b0;
            arb_err      <= 1'b1;
            if (last_grant == FETCH) fetch_rdata <= TIMEOUT_FILL;
            else                     data_rdata  <= TIMEOUT_FILL;
            fetch_done <= (last_grant == FETCH);
            data_done  <= (last_grant == DATA);
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_done;
  logic [15:0] fetch_rdata;
  logic        data_req;
  logic [15:0] data_addr;
  logic        data_we;
  logic        data_acc_sz;
  logic [15:0] data_wdata;
  logic        data_done;
  logic [15:0] data_rdata;
  logic        mem_req_rdwr;
  logic [15:0] mem_addr;
  logic        mem_data_acc_sz;
  logic        mem_we_8;
  logic        mem_we_16;
  logic [7:0]  mem_wdata_8;
  logic [15:0] mem_wdata_16;
  logic [7:0]  mem_rdata_8;
  logic [15:0] mem_rdata_16;
  logic        mem_data_ready;
  logic        arb_err;

  int vectors;
  int miscompares;

  // memory model state
  logic [7:0] mem_arr [0:65535];
  logic       mem_ready_q;
  logic       stale_ready;
  int         mem_cnt;
  int         mem_lat;
  bit         mem_en;

  logic [78:0] all_out;
  assign all_out = {fetch_done, data_done, fetch_rdata, data_rdata, mem_req_rdwr,
                    mem_addr, mem_data_acc_sz, mem_we_8, mem_we_16, mem_wdata_8,
                    mem_wdata_16, arb_err};

  mem_access_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_done      (fetch_done),
    .fetch_rdata     (fetch_rdata),
    .data_req        (data_req),
    .data_addr       (data_addr),
    .data_we         (data_we),
    .data_acc_sz     (data_acc_sz),
    .data_wdata      (data_wdata),
    .data_done       (data_done),
    .data_rdata      (data_rdata),
    .mem_req_rdwr    (mem_req_rdwr),
    .mem_addr        (mem_addr),
    .mem_data_acc_sz (mem_data_acc_sz),
    .mem_we_8        (mem_we_8),
    .mem_we_16       (mem_we_16),
    .mem_wdata_8     (mem_wdata_8),
    .mem_wdata_16    (mem_wdata_16),
    .mem_rdata_8     (mem_rdata_8),
    .mem_rdata_16    (mem_rdata_16),
    .mem_data_ready  (mem_data_ready),
    .arb_err         (arb_err)
  );

  always #5 clk = ~clk;

  assign mem_data_ready = mem_ready_q | stale_ready;

  // Memory: after mem_lat+1 edges of seeing a request, performs the access
  // and strobes ready for one cycle. Little-endian halfwords.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_ready_q  <= 1'b0;
      mem_cnt      <= 0;
      mem_rdata_8  <= 8'h00;
      mem_rdata_16 <= 16'h0000;
      mem_arr[16'h0010] <= 8'h12;
      mem_arr[16'h0011] <= 8'h34;
      mem_arr[16'h0201] <= 8'h77;
      mem_arr[16'h0300] <= 8'hCD;
      mem_arr[16'h0301] <= 8'hAB;
      mem_arr[16'hFFFF] <= 8'hEF;
      mem_arr[16'h0000] <= 8'hBE;
    end else begin
      mem_ready_q <= 1'b0;
      if (mem_en && mem_req_rdwr && !mem_ready_q) begin
        if (mem_cnt == mem_lat) begin
          mem_ready_q  <= 1'b1;
          mem_cnt      <= 0;
          mem_rdata_8  <= mem_arr[mem_addr];
          mem_rdata_16 <= {mem_arr[mem_addr + 16'd1], mem_arr[mem_addr]};
          if (mem_we_8) mem_arr[mem_addr] <= mem_wdata_8;
          if (mem_we_16) begin
            mem_arr[mem_addr]         <= mem_wdata_16[7:0];
            mem_arr[mem_addr + 16'd1] <= mem_wdata_16[15:8];
          end
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end
    end
  end

  // Runs clock edges until the wanted port's done is seen (edges = count of
  // edges since the request was driven, -1 if the limit expired). Snapshots
  // the memory-side outputs on the first cycle mem_req_rdwr is high.
  task automatic run_until_done(input bit want_data, input int limit, output int edges,
                                output logic [15:0] c_addr, output logic c_sz,
                                output logic c_we8, output logic c_we16,
                                output logic [7:0] c_wd8, output int other_done);
    bit seen;
    seen = 0; edges = -1; other_done = 0;
    c_addr = '0; c_sz = 0; c_we8 = 0; c_we16 = 0; c_wd8 = '0;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk); #1;
      if (mem_req_rdwr && !seen) begin
        seen = 1; c_addr = mem_addr; c_sz = mem_data_acc_sz;
        c_we8 = mem_we_8; c_we16 = mem_we_16; c_wd8 = mem_wdata_8;
      end
      if (want_data ? fetch_done : data_done) other_done++;
      if (want_data ? data_done : fetch_done) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    fetch_req = 0; data_req = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (all_out !== 79'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
  endtask

  task automatic test_contention;
    int  got;
    bit  order [4];
    bit  exp_o;
    fetch_addr = 16'h0010; fetch_req = 1;
    data_addr = 16'h0300; data_we = 0; data_acc_sz = 1; data_wdata = 16'h0; data_req = 1;
    mem_lat = 1;
    @(negedge clk); reset = 1'b1;
    got = 0;
    for (int n = 0; n < 80 && got < 4; n++) begin
      @(posedge clk); #1;
      if (fetch_done || data_done) begin
        order[got] = data_done;
        got++;
        if (got == 4) begin
          @(negedge clk); fetch_req = 0; data_req = 0;
        end
      end
    end
    vectors++;
    if (got !== 4) begin
      miscompares++;
      $display("FAIL contention_count: got %0d done pulses expected 4", got);
    end
    for (int i = 0; i < 4; i++) begin
      exp_o = (i % 2 == 0);
      vectors++;
      if (order[i] !== exp_o) begin
        miscompares++;
        $display("FAIL contention_order[%0d]: got data=%0b expected data=%0b", i, order[i], exp_o);
      end
    end
    vectors++;
    if (fetch_rdata !== 16'h3412 || data_rdata !== 16'hABCD) begin
      miscompares++;
      $display("FAIL contention_rdata: got %h/%h expected 3412/abcd", fetch_rdata, data_rdata);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fetch;
    int e, od, extra;
    logic [15:0] a; logic sz, w8, w16; logic [7:0] wd;
    for (int lat = 1; lat <= 2; lat++) begin
      mem_lat = lat;
      @(negedge clk); fetch_addr = 16'h0010; fetch_req = 1;
      run_until_done(1'b0, 20, e, a, sz, w8, w16, wd, od);
      @(negedge clk); fetch_req = 0;
      vectors++;
      if (e !== lat + 3) begin
        miscompares++;
        $display("FAIL fetch_latency: got %0d cycles expected %0d", e, lat + 3);
      end
      vectors++;
      if (a !== 16'h0010 || sz !== 1'b1 || w8 !== 1'b0 || w16 !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_request: got addr=%h sz=%b we8=%b we16=%b expected 0010 1 0 0", a, sz, w8, w16);
      end
      vectors++;
      if (fetch_rdata !== 16'h3412 || od !== 0) begin
        miscompares++;
        $display("FAIL fetch_rdata: got %h other_done=%0d expected 3412 0", fetch_rdata, od);
      end
      extra = 0;
      repeat (5) begin
        @(posedge clk); #1;
        if (fetch_done) extra++;
      end
      vectors++;
      if (extra !== 0) begin
        miscompares++;
        $display("FAIL fetch_single_pulse: got %0d extra pulses expected 0", extra);
      end
    end
  endtask

  task automatic test_write_read_8;
    int e, od;
    logic [15:0] a; logic sz, w8, w16; logic [7:0] wd;
    mem_lat = 1;
    @(negedge clk);
    data_addr = 16'h0200; data_we = 1; data_acc_sz = 0; data_wdata = 16'h5BA5; data_req = 1;
    run_until_done(1'b1, 20, e, a, sz, w8, w16, wd, od);
    @(negedge clk); data_req = 0;
    vectors++;
    if (e < 0 || w8 !== 1'b1 || w16 !== 1'b0 || wd !== 8'hA5 || a !== 16'h0200 || sz !== 1'b0) begin
      miscompares++;
      $display("FAIL write8_request: got e=%0d we8=%b we16=%b wd=%h addr=%h sz=%b expected we8=1 we16=0 a5 0200 0",
               e, w8, w16, wd, a, sz);
    end
    vectors++;
    if (data_rdata !== 16'hABCD || mem_we_8 !== 1'b0) begin
      miscompares++;
      $display("FAIL write8_after: got rdata=%h we8=%b expected abcd 0", data_rdata, mem_we_8);
    end
    repeat (2) @(negedge clk);
    data_we = 0; data_req = 1;
    run_until_done(1'b1, 20, e, a, sz, w8, w16, wd, od);
    @(negedge clk); data_req = 0;
    vectors++;
    if (e < 0 || w8 !== 1'b0 || data_rdata !== 16'h00A5) begin
      miscompares++;
      $display("FAIL read8: got e=%0d we8=%b rdata=%h expected we8=0 rdata=00a5", e, w8, data_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_addr_ffff;
    int e, od;
    logic [15:0] a; logic sz, w8, w16; logic [7:0] wd;
    mem_lat = 2;
    @(negedge clk);
    data_addr = 16'hFFFF; data_we = 0; data_acc_sz = 1; data_req = 1;
    run_until_done(1'b1, 20, e, a, sz, w8, w16, wd, od);
    @(negedge clk); data_req = 0;
    vectors++;
    if (a !== 16'hFFFF || data_rdata !== 16'hBEEF || e !== 5) begin
      miscompares++;
      $display("FAIL addr_ffff: got addr=%h rdata=%h e=%0d expected ffff beef 5", a, data_rdata, e);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop_in_wait;
    bit seen; int dones, rises; logic prev;
    mem_lat = 2;
    @(negedge clk);
    data_addr = 16'h0300; data_we = 0; data_acc_sz = 1; data_req = 1;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk); #1;
      if (mem_req_rdwr) seen = 1;
    end
    @(negedge clk); data_req = 0;
    dones = 0; rises = 0; prev = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (data_done) dones++;
      if (mem_req_rdwr && !prev) rises++;
      prev = mem_req_rdwr;
    end
    vectors++;
    if (!seen || dones !== 1 || rises !== 0 || data_rdata !== 16'hABCD) begin
      miscompares++;
      $display("FAIL drop_in_wait: got seen=%0b dones=%0d rises=%0d rdata=%h expected 1 1 0 abcd",
               seen, dones, rises, data_rdata);
    end
  endtask

  task automatic test_reset_mid_wait;
    bit seen; int dones, reqs, e, od;
    logic [15:0] a; logic sz, w8, w16; logic [7:0] wd;
    mem_lat = 2;
    @(negedge clk);
    data_addr = 16'h0400; data_we = 1; data_acc_sz = 1; data_wdata = 16'h1234; data_req = 1;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk); #1;
      if (mem_req_rdwr) seen = 1;
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (!seen || all_out !== 79'd0) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got seen=%0b outputs=%h expected 1 0", seen, all_out);
    end
    data_req = 0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); stale_ready = 1'b1;
    dones = 0; reqs = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (fetch_done || data_done) dones++;
      if (mem_req_rdwr) reqs++;
      if (n == 0) stale_ready = 1'b0;
    end
    vectors++;
    if (dones !== 0 || reqs !== 0) begin
      miscompares++;
      $display("FAIL stale_ready: got dones=%0d req_cycles=%0d expected 0 0", dones, reqs);
    end
    mem_lat = 1;
    @(negedge clk); fetch_addr = 16'h0010; fetch_req = 1;
    run_until_done(1'b0, 20, e, a, sz, w8, w16, wd, od);
    @(negedge clk); fetch_req = 0;
    vectors++;
    if (e !== 4 || fetch_rdata !== 16'h3412) begin
      miscompares++;
      $display("FAIL fetch_after_reset: got e=%0d rdata=%h expected 4 3412", e, fetch_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef MEM_ACCESS_ARBITER_TIMEOUT_EN
  task automatic test_timeout;
    int e, od;
    logic [15:0] a; logic sz, w8, w16; logic [7:0] wd;
    mem_en = 0;
    @(negedge clk); fetch_addr = 16'h0010; fetch_req = 1;
    run_until_done(1'b0, 60, e, a, sz, w8, w16, wd, od);
    vectors++;
    if (e !== 33 || fetch_rdata !== 16'hDEAD || arb_err !== 1'b1 || mem_req_rdwr !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout: got e=%0d rdata=%h err=%b req=%b expected 33 dead 1 0",
               e, fetch_rdata, arb_err, mem_req_rdwr);
    end
    @(negedge clk); fetch_req = 0;
    repeat (4) @(negedge clk);
    vectors++;
    if (arb_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: got %b expected 1", arb_err);
    end
    mem_en = 1;
  endtask
`else
  task automatic test_no_timeout;
    vectors++;
    if (arb_err !== 1'b0) begin
      miscompares++;
      $display("FAIL arb_err_tied: got %b expected 0", arb_err);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0;
    clk = 0;
    mem_en = 1; mem_lat = 1; stale_ready = 0;
    fetch_req = 0; fetch_addr = 16'h0; data_req = 0; data_addr = 16'h0;
    data_we = 0; data_acc_sz = 0; data_wdata = 16'h0;
    reset = 1'b1;
    #1 reset = 1'b0;
    test_reset;
    test_contention;
    test_fetch;
    test_write_read_8;
    test_addr_ffff;
    test_drop_in_wait;
    test_reset_mid_wait;
`ifdef MEM_ACCESS_ARBITER_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Two-port bus arbiter directly upstream of the synchronous test memory.
- Merges the CPU instruction-fetch port and load/store data port into one memory request stream.
- Drives the memory's req_rdwr/addr/size/write-enable inputs, waits for data_ready, then returns read data and a one-cycle done pulse to the granted requester.

Parameters:
- ADDR_WIDTH, 16, byte address width (64 KiB space).
- TIMEOUT_CYCLES, 8'd32, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request; requester holds it high until fetch_done.
- fetch_addr  in  ADDR_WIDTH  fetch byte address; always a 16-bit read.
- fetch_done  out  1  one-cycle pulse: fetch_rdata valid.
- fetch_rdata  out  16  fetched halfword.
- data_req  in  1  data request; requester holds it high until data_done.
- data_addr  in  ADDR_WIDTH  data byte address.
- data_we  in  1  1 = write, 0 = read.
- data_acc_sz  in  1  pkg_cpu::cpu_data_acc_sz_8 / _16.
- data_wdata  in  16  write data; bits [7:0] used for 8-bit writes.
- data_done  out  1  one-cycle pulse: access complete.
- data_rdata  out  16  read data; 8-bit reads are zero-extended.
- mem_req_rdwr  out  1  to memory req_rdwr.
- mem_addr  out  ADDR_WIDTH  to memory addr_in.
- mem_data_acc_sz  out  1  to memory data_acc_sz.
- mem_we_8, mem_we_16  out  1 each  to memory write enables.
- mem_wdata_8  out  8  write data, low byte.
- mem_wdata_16  out  16  write data, halfword.
- mem_rdata_8  in  8  read data from memory, 8-bit access.
- mem_rdata_16  in  16  read data from memory, 16-bit access.
- mem_data_ready  in  1  memory completion strobe.
- arb_err  out  1  timeout flag; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = FETCH (so data wins the first contention).
- All outputs are registered.
- States:
  - IDLE:
    - No request pending: stay in IDLE.
    - One request pending: grant it.
    - Both pending: grant the port opposite to last_grant (round-robin).
    - On grant, latch addr/size/we/wdata into the mem_* registers, set mem_req_rdwr=1, update last_grant, go to WAIT.
    - A fetch grant forces size = 16 and we = 0.
  - WAIT:
    - Hold every mem_* output stable.
    - On a sampled mem_data_ready=1: clear mem_req_rdwr and the write enables on that same edge.
    - Also on that edge, capture read data: mem_rdata_16 for 16-bit, {8'h0, mem_rdata_8} for 8-bit. Writes leave rdata unchanged.
    - Then go to RESP.
  - RESP:
    - Pulse the granted port's done for exactly 1 cycle, then return to IDLE.
    - A new grant can occur on the following edge, so there is at least one idle bus cycle between requests.
- Write enables: mem_we_8 = we & (size == 8); mem_we_16 = we & (size == 16).
- Latency: req seen at edge N → mem_req_rdwr high after N. Memory accepts on its next can_rdwr phase (1–2 cycles). done is high 1 cycle after data_ready is sampled. Minimum total is 4 cycles, maximum 5.
- Boundaries:
  - A requester dropping req in WAIT does not cancel the access; done still pulses.
  - mem_data_ready seen in IDLE or RESP is ignored (stale strobe, e.g. after reset).
  - Address 16'hFFFF with a 16-bit access is passed through unchanged; memory wrap is the memory's concern.
  - Reset asserted mid-WAIT returns to IDLE at once with all outputs 0; the in-flight memory write may still complete.
  - Back-to-back requests from one port while the other is pending alternate strictly.

Optional Feature:
- Macro: MEM_ACCESS_ARBITER_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
- Timeout: reaching TIMEOUT_CYCLES without data_ready drops mem_req_rdwr, sets arb_err (sticky until reset), pulses the granted done with rdata = 16'hDEAD, and goes to IDLE.
- Undefined: no counter, WAIT waits forever, arb_err = 0.

Decomposition:
- Package pkg_mem_arb:
  - enum arb_state_t {IDLE, WAIT, RESP}.
  - enum arb_port_t {FETCH, DATA}.
  - localparam timeout fill value 16'hDEAD.
  - Reuses pkg_cpu size constants.
- Sub-module mem_arb_rr_pick: combinational 2-way round-robin picker.
  - Inputs: fetch_req, data_req, last_grant.
  - Outputs: grant_valid, grant_port.

Test Plan:
- Fetch-only: fetch_addr=16'h0010, memory holds 12 34 at 0x10 → one 16-bit read to 0x0010; fetch_done pulses once with fetch_rdata = memory's make_pair of those bytes; done arrives 4–5 cycles after req.
- 8-bit write then read: write 8'hA5 to 16'h0200, then read 8-bit → mem_we_8=1 for the write only; data_rdata = 16'h00A5.
- Contention: both req asserted from reset and held high → grant order DATA, FETCH, DATA, FETCH; there are never two consecutive done pulses on the same port.
- Requester drops data_req during WAIT → access still completes; data_done pulses once; no second mem_req_rdwr.
- Reset low mid-WAIT → all outputs 0 immediately. A stale mem_data_ready after reset produces no done pulse, and the next fetch completes normally.
- With MEM_ACCESS_ARBITER_TIMEOUT_EN and mem_data_ready tied 0 → after 32 WAIT cycles fetch_done=1, fetch_rdata=16'hDEAD, arb_err=1 (sticky).
